led_top: RTL and testbench

- NeoPixel (WS2812-style) LED strip controller for the MAX10 board.
- Receives command and pixel bytes over a write-only SPI-like link (SPI_CLK, data, active-low le, DC) and stores pixel bytes in an internal frame buffer.
- On command, serializes the buffer onto the single-wire output zerodata with WS2812 pulse-width timing.
- All logic runs on inclk; SPI pins are treated as asynchronous inputs and oversampled.

---
 rtl/led_top_pkg.sv | 18 +
 rtl/ws2812_tx.sv | 123 ++++++++++++
 rtl/led_top.sv | 133 +++++++++++++
 tb/tb_led_top.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_top_pkg.sv
// Shared definitions for the WS2812 LED strip controller:
// SPI command codes, the byte type and the encoder state encoding.
package led_top_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t CMD_WR   = 8'hDA;
    localparam byte_t CMD_SHOW = 8'hDB;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        LATCH
    } tx_state_t;

endpackage

// File: rtl/ws2812_tx.sv
// WS2812 frame encoder: walks the frame buffer byte by byte and emits
// each bit MSB first as a pulse-width coded high/low pair, then holds the
// line low for the latch time. A start request that arrives while a frame
// is in flight is remembered and honoured straight after the latch period.
module ws2812_tx
    import led_top_pkg::*;
#(
    parameter int NUM_LEDS = 64,
    parameter int BIT_CYC  = 63,
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int RST_CYC  = 15000,
    localparam int NBYTES  = NUM_LEDS * 3,
    localparam int AW      = $clog2(NBYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic [AW-1:0] addr,
    input  byte_t         rdata,
    output logic          zerodata
);

    localparam int MAXC = (RST_CYC > BIT_CYC) ? RST_CYC : BIT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    byte_t         shreg;
    logic [AW-1:0] byte_idx;
    logic          pending;
    logic [CW-1:0] hi_last;

    // The byte index advances as soon as a byte is latched, so the buffer
    // read for the next byte has a whole byte time to settle before LOAD.
    assign addr = byte_idx;
    assign busy = (state != IDLE);

    // Last HIGH count of the bit currently being sent.
    always_comb begin
        hi_last = shreg[7] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
    end

    // Encoder FSM; zerodata is registered and is high exactly in HIGH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            zerodata <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            pending  <= 1'b0;
        end else begin
            if (start && state != IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    zerodata <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg    <= rdata;
                    byte_idx <= byte_idx + AW'(1);
                    bit_idx  <= 3'd7;
                    cnt      <= '0;
                    zerodata <= 1'b1;
                    state    <= HIGH;
                end
                HIGH: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == hi_last) begin
                        zerodata <= 1'b0;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == CW'(BIT_CYC - 1)) begin
                        cnt <= '0;
                        if (bit_idx == 3'd0) begin
                            if (byte_idx == AW'(NBYTES)) begin
                                byte_idx <= '0;
                                state    <= LATCH;
                            end else begin
                                state <= LOAD;
                            end
                        end else begin
                            bit_idx  <= bit_idx - 3'd1;
                            shreg    <= {shreg[6:0], 1'b0};
                            zerodata <= 1'b1;
                            state    <= HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LATCH: begin
                    if (cnt == CW'(RST_CYC - 1)) begin
                        cnt <= '0;
                        if (pending || start) begin
                            pending <= 1'b0;
                            state   <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    zerodata <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/led_top.sv
// NeoPixel strip controller top: oversampled SPI-like receiver, command
// decode and frame buffer, driving the ws2812_tx encoder.
// Optional build macro LEDTOP_AUTO_SHOW_EN: filling the last buffer
// location starts a frame as if CMD_SHOW had been received.
module led_top
    import led_top_pkg::*;
#(
    parameter int NUM_LEDS = 64,
    parameter int BIT_CYC  = 63,
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int RST_CYC  = 15000
) (
    input  logic inclk,
    input  logic rst,
    input  logic SPI_CLK,
    input  logic data,
    input  logic le,
    input  logic DC,
    output logic zerodata
);

    localparam int NBYTES = NUM_LEDS * 3;
    localparam int AW     = $clog2(NBYTES + 1);

    logic [1:0]    sck_sync, dat_sync, le_sync, dc_sync;
    logic          sck_prev;
    logic          sck_s, dat_s, le_s, dc_s, sck_rise;
    logic [2:0]    bitcnt;
    logic [6:0]    sr;
    byte_t         new_byte;
    logic          byte_done, is_cmd, wr_ok, show_cmd;
    logic [AW-1:0] wptr;
    logic          wen;
    byte_t         mem [NBYTES];
    byte_t         rdata;
    logic [AW-1:0] rd_addr;
    logic          tx_start, tx_busy;

    // Two-flop synchronizers for the asynchronous SPI pins.
    always_ff @(posedge inclk) begin
        if (rst) begin
            sck_sync <= '0;
            dat_sync <= '0;
            le_sync  <= '1;
            dc_sync  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], SPI_CLK};
            dat_sync <= {dat_sync[0], data};
            le_sync  <= {le_sync[0], le};
            dc_sync  <= {dc_sync[0], DC};
            sck_prev <= sck_sync[1];
        end
    end

    assign sck_s    = sck_sync[1];
    assign dat_s    = dat_sync[1];
    assign le_s     = le_sync[1];
    assign dc_s     = dc_sync[1];
    assign sck_rise = sck_s & ~sck_prev;

    // Byte assembly and decode happen on the same sampled edge.
    always_comb begin
        new_byte  = {sr, dat_s};
        byte_done = ~le_s & sck_rise & (bitcnt == 3'd7);
        is_cmd    = byte_done & ~dc_s;
        wr_ok     = byte_done & dc_s & wen & (wptr < AW'(NBYTES));
        show_cmd  = is_cmd & (new_byte == CMD_SHOW);
`ifdef LEDTOP_AUTO_SHOW_EN
        tx_start  = show_cmd | (wr_ok & (wptr == AW'(NBYTES - 1)));
`else
        tx_start  = show_cmd;
`endif
    end

    // Shift register, bit counter, write pointer and write-enable.
    always_ff @(posedge inclk) begin
        if (rst) begin
            bitcnt <= '0;
            sr     <= '0;
            wptr   <= '0;
            wen    <= 1'b0;
        end else begin
            if (le_s) begin
                bitcnt <= '0;
            end else if (sck_rise) begin
                sr     <= new_byte[6:0];
                bitcnt <= bitcnt + 3'd1;
            end
            if (is_cmd) begin
                if (new_byte == CMD_WR) begin
                    wptr <= '0;
                    wen  <= 1'b1;
                end else if (new_byte != CMD_SHOW) begin
                    wen <= 1'b0;
                end
            end
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
        end
    end

    // Frame buffer write port; contents survive reset.
    always_ff @(posedge inclk) begin
        if (wr_ok) begin
            mem[wptr] <= new_byte;
        end
    end

    // Registered read port feeding the encoder (one cycle of latency).
    always_ff @(posedge inclk) begin
        rdata <= (rd_addr < AW'(NBYTES)) ? mem[rd_addr] : '0;
    end

    ws2812_tx #(
        .NUM_LEDS (NUM_LEDS),
        .BIT_CYC  (BIT_CYC),
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .RST_CYC  (RST_CYC)
    ) u_tx (
        .clk      (inclk),
        .rst      (rst),
        .start    (tx_start),
        .busy     (tx_busy),
        .addr     (rd_addr),
        .rdata    (rdata),
        .zerodata (zerodata)
    );

endmodule

// File: tb/tb_led_top.sv
// Scoreboard bench for led_top: stimulus pushes the expected pulse
// train of every frame it triggers, a monitor measures the high and low
// widths on zerodata and compares them against the queue.
module tb_led_top;
    import led_top_pkg::*;

    localparam int NL   = 1;
    localparam int BC   = 10;
    localparam int T0   = 3;
    localparam int T1   = 6;
    localparam int RC   = 20;
    localparam int HALF = 4;

    logic inclk = 1'b0;
    logic rst, SPI_CLK, data, le, DC;
    logic zerodata;

    always #5 inclk = ~inclk;

    led_top #(
        .NUM_LEDS (NL),
        .BIT_CYC  (BC),
        .T0H_CYC  (T0),
        .T1H_CYC  (T1),
        .RST_CYC  (RC)
    ) dut (
        .inclk    (inclk),
        .rst      (rst),
        .SPI_CLK  (SPI_CLK),
        .data     (data),
        .le       (le),
        .DC       (DC),
        .zerodata (zerodata)
    );

    typedef struct {
        int hi;
        int lo;
        bit lo_min;
    } pulse_t;

    pulse_t exp_q[$];
    bit     mon_en = 1'b0;
    int     total  = 0;
    int     passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_ge(input string name, input int act, input int lim);
        total++;
        if (act >= lim) passed++;
        else $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge inclk);
    endtask

    task automatic spi_bits(input bit dc, input byte_t b, input int nbits);
        DC      = dc;
        SPI_CLK = 1'b0;
        le      = 1'b0;
        cycles(HALF);
        for (int i = 7; i > 7 - nbits; i--) begin
            data = b[i];
            cycles(HALF);
            SPI_CLK = 1'b1;
            cycles(HALF);
            SPI_CLK = 1'b0;
        end
        cycles(HALF);
        le = 1'b1;
        cycles(HALF);
    endtask

    task automatic spi_byte(input bit dc, input byte_t b);
        spi_bits(dc, b, 8);
    endtask

    // Expected pulses of one 3-byte frame; the last bit's low time covers
    // LATCH plus the LOAD cycle of a chained frame (exact) or is a minimum.
    task automatic push_frame(input byte_t b0, input byte_t b1, input byte_t b2, input bit chained);
        byte_t  bs [3];
        pulse_t p;
        bs[0] = b0;
        bs[1] = b1;
        bs[2] = b2;
        for (int i = 0; i < 3; i++) begin
            for (int j = 7; j >= 0; j--) begin
                p.hi     = bs[i][j] ? T1 : T0;
                p.lo     = BC - p.hi;
                p.lo_min = 1'b0;
                if (j == 0) begin
                    if (i < 2) begin
                        p.lo = p.lo + 1;
                    end else begin
                        p.lo     = p.lo + RC + 1;
                        p.lo_min = !chained;
                    end
                end
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (dut.tx_busy && n < budget) begin
            cycles(1);
            n++;
        end
        chk("frame_done_busy", int'(dut.tx_busy), 0);
    endtask

    // Monitor: measure pulse widths on zerodata and check against the queue.
    initial begin
        bit     prev, have_prev;
        int     hi_cnt, lo_cnt;
        pulse_t cur;
        prev      = 1'b0;
        have_prev = 1'b0;
        hi_cnt    = 0;
        lo_cnt    = 0;
        forever begin
            @(negedge inclk);
            if (!mon_en) begin
                prev      = 1'b0;
                have_prev = 1'b0;
                hi_cnt    = 0;
                lo_cnt    = 0;
            end else if (zerodata) begin
                if (!prev) begin
                    if (have_prev) begin
                        if (cur.lo_min) chk_ge("low_gap", lo_cnt, cur.lo);
                        else            chk("low_time", lo_cnt, cur.lo);
                    end
                    have_prev = 1'b0;
                    hi_cnt    = 1;
                end else begin
                    hi_cnt++;
                end
                prev = 1'b1;
            end else begin
                if (prev) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_pulse: width %0d, expected no pulse", hi_cnt);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("high_time", hi_cnt, cur.hi);
                        have_prev = 1'b1;
                        lo_cnt    = 0;
                    end
                end
                if (have_prev) lo_cnt++;
                prev = 1'b0;
            end
        end
    end

    initial begin
        int n, highs;
        rst     = 1'b1;
        SPI_CLK = 1'b0;
        data    = 1'b0;
        le      = 1'b1;
        DC      = 1'b0;
        cycles(5);
        chk("rst_zerodata", int'(zerodata), 0);
        chk("rst_state", int'(dut.u_tx.state), int'(IDLE));
        chk("rst_wptr", int'(dut.wptr), 0);
        chk("rst_bitcnt", int'(dut.bitcnt), 0);
        chk("rst_wen", int'(dut.wen), 0);
        chk("rst_pending", int'(dut.u_tx.pending), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        cycles(5);

        // Load FF,00,A5
`ifdef LEDTOP_AUTO_SHOW_EN
        push_frame(8'hFF, 8'h00, 8'hA5, 1'b1);
`endif
        spi_byte(1'b0, CMD_WR);
        spi_byte(1'b1, 8'hFF);
        spi_byte(1'b1, 8'h00);
        spi_byte(1'b1, 8'hA5);
        chk("wr_wptr", int'(dut.wptr), 3);
        chk("wr_wen", int'(dut.wen), 1);
        chk("mem0", int'(dut.mem[0]), 8'hFF);
        chk("mem1", int'(dut.mem[1]), 8'h00);
        chk("mem2", int'(dut.mem[2]), 8'hA5);

        // Explicit show
        push_frame(8'hFF, 8'h00, 8'hA5, 1'b0);
        spi_byte(1'b0, CMD_SHOW);
        chk("show_busy", int'(dut.tx_busy), 1);
        wait_idle(2000);
        chk("show_queue_empty", exp_q.size(), 0);

        // Overflow byte is dropped
        spi_byte(1'b1, 8'h77);
        chk("ovf_wptr", int'(dut.wptr), 3);
        chk("ovf_mem0", int'(dut.mem[0]), 8'hFF);
        chk("ovf_mem2", int'(dut.mem[2]), 8'hA5);

        // Partial byte discarded, then a full show still starts a frame
        spi_bits(1'b0, CMD_SHOW, 5);
        chk("partial_bitcnt", int'(dut.bitcnt), 0);
        chk("partial_no_start", int'(dut.tx_busy), 0);
        push_frame(8'hFF, 8'h00, 8'hA5, 1'b0);
        spi_byte(1'b0, CMD_SHOW);
        chk("partial_show_busy", int'(dut.tx_busy), 1);
        wait_idle(2000);
        chk("partial_queue_empty", exp_q.size(), 0);

        // Show during transmission chains a second frame after LATCH
        push_frame(8'hFF, 8'h00, 8'hA5, 1'b1);
        push_frame(8'hFF, 8'h00, 8'hA5, 1'b0);
        spi_byte(1'b0, CMD_SHOW);
        spi_byte(1'b0, CMD_SHOW);
        chk("pending_set", int'(dut.u_tx.pending), 1);
        wait_idle(3000);
        chk("pending_queue_empty", exp_q.size(), 0);
        chk("pending_cleared", int'(dut.u_tx.pending), 0);

        // Filling the buffer: auto-show only when the feature is built in
        spi_byte(1'b0, CMD_WR);
        spi_byte(1'b1, 8'h11);
        spi_byte(1'b1, 8'h22);
`ifdef LEDTOP_AUTO_SHOW_EN
        push_frame(8'h11, 8'h22, 8'h33, 1'b0);
        spi_byte(1'b1, 8'h33);
        chk("auto_busy", int'(dut.tx_busy), 1);
`else
        spi_byte(1'b1, 8'h33);
        cycles(50);
        chk("no_auto_busy", int'(dut.tx_busy), 0);
        push_frame(8'h11, 8'h22, 8'h33, 1'b0);
        spi_byte(1'b0, CMD_SHOW);
`endif
        wait_idle(2000);
        chk("fill_queue_empty", exp_q.size(), 0);

        // Reset mid-bit: output low next edge, no partial frame resumes
        mon_en = 1'b0;
        spi_byte(1'b0, CMD_SHOW);
        n = 0;
        while (!zerodata && n < 500) begin
            cycles(1);
            n++;
        end
        chk("rstmid_started", int'(zerodata), 1);
        cycles(2);
        rst = 1'b1;
        @(posedge inclk);
        #1;
        chk("rstmid_zerodata", int'(zerodata), 0);
        chk("rstmid_state", int'(dut.u_tx.state), int'(IDLE));
        @(negedge inclk);
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge inclk);
            if (zerodata) highs++;
        end
        chk("rstmid_no_resume", highs, 0);
        chk("rstmid_wptr", int'(dut.wptr), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
